// File: rtl/root_pkg.sv
// Shared types and helpers for the arbitrated integer root engine.
package root_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_SQ = 1'b0;
   localparam logic MODE_CB = 1'b1;

   // Number of result bits the engine resolves for an operand of the given width.
   function automatic int unsigned root_width(input logic mode, input int unsigned width);
      return (mode == MODE_CB) ? (width + 2) / 3 : width / 2;
   endfunction

endpackage

// File: rtl/root_sched_if.sv
// Request/response bundle between the requesters plus consumer (master) and the scheduler (slave).
interface root_sched_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_mode;
   logic [NREQ*WIDTH-1:0] req_num;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_mode;
   logic [WIDTH-1:0]      rsp_root;

   modport master (
      output req_valid, req_mode, req_num, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_mode, rsp_root
   );

   modport slave (
      input  req_valid, req_mode, req_num, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_mode, rsp_root
   );
endinterface

// File: rtl/root_iter_core.sv
// Bit-serial floor square/cube root: resolves one result bit per cycle, MSB first.
module root_iter_core
   import root_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SQ_W  = 16,
   parameter int CB_W  = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] num,
   output logic             done,
   output logic [WIDTH-1:0] root
);
   localparam int RW  = (SQ_W > CB_W) ? SQ_W : CB_W;
   localparam int KW  = (RW > 1) ? $clog2(RW) : 1;
   localparam int PW0 = (2 * SQ_W > 3 * CB_W) ? 2 * SQ_W : 3 * CB_W;
   localparam int PW  = (PW0 > WIDTH) ? PW0 : WIDTH;

   logic [RW-1:0]    res;
   logic [RW-1:0]    cand;
   logic [KW-1:0]    k;
   logic             active;
   logic             mode_q;
   logic [WIDTH-1:0] num_q;
   logic [PW-1:0]    cand_ext;
   logic [PW-1:0]    num_ext;
   logic [PW-1:0]    prod;

   // cand never exceeds the mode's result width, so the PW-wide product cannot overflow.
   always_comb begin
      cand     = res | (RW'(1) << k);
      cand_ext = PW'(cand);
      num_ext  = PW'(num_q);
      prod     = (mode_q == MODE_CB) ? cand_ext * cand_ext * cand_ext
                                     : cand_ext * cand_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res    <= '0;
         k      <= '0;
         active <= 1'b0;
         done   <= 1'b0;
         mode_q <= 1'b0;
         num_q  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            num_q  <= num;
            mode_q <= mode;
            res    <= '0;
            k      <= (mode == MODE_CB) ? KW'(CB_W - 1) : KW'(SQ_W - 1);
            active <= 1'b1;
         end else if (active) begin
            if (prod <= num_ext) res <= cand;
            if (k == '0) begin
               active <= 1'b0;
               done   <= 1'b1;
            end else begin
               k <= k - 1'b1;
            end
         end
      end
   end

   assign root = WIDTH'(res);

endmodule

// File: rtl/root_sched.sv
// Round-robin front end sharing one bit-serial root engine among NREQ requesters.
//   state | meaning
//   IDLE  | searching for a requester from rr_ptr; grantee sees req_ready
//   CALC  | engine resolving result bits; waits for its done pulse
//   DONE  | response held on rsp_* until the consumer takes it
module root_sched
   import root_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2,
   parameter int SQ_W  = int'(root_width(MODE_SQ, WIDTH)),
   parameter int CB_W  = int'(root_width(MODE_CB, WIDTH))
) (
   input  logic        clk,
   input  logic        rst_n,
   root_sched_if.slave bus,
   output logic        busy
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t           state;
   state_t           state_nx;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   scan;
   logic [IDW-1:0]   cur_id;
   logic             gnt_found;
   logic             start;
   logic             cur_mode;
   logic             core_done;
   logic [WIDTH-1:0] core_root;
   logic [WIDTH-1:0] num_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_num
      assign num_arr[gi] = bus.req_num[gi*WIDTH +: WIDTH];
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan = IDW'((int'(rr_ptr) + i) % NREQ);
         if (!gnt_found && bus.req_valid[scan]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      start         = 1'b0;
      bus.req_ready = '0;
      unique case (state)
         IDLE: begin
            if (gnt_found) begin
               bus.req_ready[gnt_idx] = 1'b1;
               start                  = 1'b1;
               state_nx               = CALC;
            end
         end
         CALC:    if (core_done)     state_nx = DONE;
         DONE:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // rsp_root/id/mode keep their last value after the handshake; only rsp_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr        <= '0;
         cur_id        <= '0;
         cur_mode      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_mode  <= 1'b0;
         bus.rsp_root  <= '0;
      end else begin
         if (start) begin
            rr_ptr   <= IDW'((int'(gnt_idx) + 1) % NREQ);
            cur_id   <= gnt_idx;
            cur_mode <= bus.req_mode[gnt_idx];
         end
         if (state == CALC && core_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur_id;
            bus.rsp_mode  <= cur_mode;
            bus.rsp_root  <= core_root;
         end else if (state == DONE && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

   root_iter_core #(
      .WIDTH (WIDTH),
      .SQ_W  (SQ_W),
      .CB_W  (CB_W)
   ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (bus.req_mode[gnt_idx]),
      .num   (num_arr[gnt_idx]),
      .done  (core_done),
      .root  (core_root)
   );

endmodule

// File: doc/root_sched.md
Name: root_sched

Overview:
- Arbitrated front end plus bit-serial datapath for integer floor square root and floor cube root.
- Shares one iterative root engine among NREQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Replaces the combinational root tasks wherever multiple clients need roots without replicated multipliers.

Parameters:
- WIDTH, 32, operand width in bits.
- NREQ, 2, number of requester ports (2..8).
- SQ_W, WIDTH/2, square-root result width (16 at default).
- CB_W, (WIDTH+2)/3, cube-root result width (11 at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_mode  in  NREQ  per-requester mode; 0 = square root, 1 = cube root.
- req_num  in  NREQ*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(NREQ) (min 1)  index of the requester that owns the result.
- rsp_mode  out  1  mode of the result.
- rsp_root  out  WIDTH  floor root, zero-extended.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_mode=0, rsp_root=0, busy=0, all internal registers 0.
- Reset asserted in any state aborts the operation. No response is produced for the aborted request.
- States: IDLE, CALC, DONE.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready[g] is high combinationally only in IDLE and only for the grantee.
  - On handshake, at edge T: latch num, mode and id; rr_ptr <= (g+1) mod NREQ; res <= 0; k <= (mode ? CB_W : SQ_W) - 1; go to CALC.
  - No valid requester: stay in IDLE; rr_ptr unchanged.
- CALC, one result bit per cycle:
  - cand = res | (1<<k).
  - Square root: cand*cand. Cube root: cand*cand*cand.
  - Products are computed at 3*CB_W (or 2*SQ_W) bits with no truncation.
  - If product <= num, res <= cand.
  - If k==0, go to DONE; else k <= k-1.
  - Square root occupies SQ_W CALC cycles; cube root occupies CB_W.
- DONE:
  - rsp_valid=1; rsp_root, rsp_id and rsp_mode are held stable until rsp_ready=1.
  - On rsp_valid and rsp_ready: rsp_valid <= 0 and state goes to IDLE.
  - rsp_root stays at its last value after the handshake.
  - No bypass: at least one IDLE cycle between results.
- Latency from accept edge T: rsp_valid rises at edge T+SQ_W+1 for square root (17 at default) and T+CB_W+1 for cube root (12 at default).
- Requester rules:
  - Requester must hold req_valid, req_num and req_mode stable until its ready.
  - Operand changes while not granted are ignored.
  - Dropping valid before ready withdraws the request; this is legal.
- Arithmetic limits: WIDTH=32 with num=0xFFFFFFFF gives square root 65535 and cube root 1625. num=0 gives 0 in both modes.
- Simultaneous events:
  - All requesters valid: strict rotation, one grant per IDLE visit.
  - A requester re-asserting immediately after its grant waits behind the other pending requesters.
- rsp_ready held low: the engine stalls in DONE indefinitely. req_ready stays 0 and no request is lost.

Decomposition:
- Package root_pkg:
  - state enum {IDLE, CALC, DONE}.
  - mode constants MODE_SQ=0 and MODE_CB=1.
  - function returning the result width per mode.
- Sub-module root_iter_core, the bit-serial datapath:
  - inputs: start, mode, num.
  - outputs: done, root.
  - holds the res and k registers and the comparator.
- root_sched keeps arbitration, the FSM and the response registers.

Test Plan:
- Square root sweep, requester 0: num=144 -> root 12, id 0, rsp_valid 17 cycles after accept. num=143 -> 11. num=0 -> 0. num=0xFFFFFFFF -> 65535.
- Cube root, requester 1: num=27 -> 3 and num=26 -> 2, each with rsp_valid 12 cycles after accept. num=1000 -> 10. num=0xFFFFFFFF -> 1625.
- Contention: both requesters valid continuously with 4 requests each -> grants alternate 0,1,0,1,...; rsp_id matches; results are correct and in order.
- Back-pressure: rsp_ready=0 for 20 cycles after a result -> rsp_valid and rsp_root stay stable; busy=1; req_ready=0 throughout; release -> IDLE on the next edge.
- Reset mid-CALC: assert rst_n=0 at the 5th CALC cycle -> all outputs return to reset values immediately; no rsp_valid; next request (num=81, sqrt) -> root 9.
- Withdrawn request: requester 1 drops valid before grant while requester 0 is busy -> only requester 0's result appears; rr_ptr=1 afterwards.
